// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA scanout block.
package vga_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // One axis of the raster, in clocks (horizontal) or lines (vertical).
  typedef struct packed {
    logic [9:0] active;
    logic [9:0] fp;
    logic [9:0] sync;
    logic [9:0] bp;
  } axis_timing_t;

  function automatic logic [9:0] axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic logic in_sync(input logic [9:0] c, input axis_timing_t t);
    return (c >= t.active + t.fp) && (c < t.active + t.fp + t.sync);
  endfunction

endpackage

// File: rtl/vga_word_fifo.sv
// Show-ahead word FIFO with synchronous flush; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module vga_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok) && !flush;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster timing generator with a prefetching framebuffer reader that
// unpacks 32-bit words into BPP-wide pixels, MSB first.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter int   BPP        = 1,
  parameter int   FIFO_DEPTH = 16,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [31:0]    fb_base,
  output logic           mem_req,
  output logic [31:0]    mem_addr,
  input  logic           mem_ack,
  input  logic [31:0]    mem_rdata,
  output logic           h_sync,
  output logic           v_sync,
  output logic           data_en,
  output logic [BPP-1:0] pixel_out,
  output logic           frame_start,
  output logic [9:0]     h_count,
  output logic [9:0]     v_count,
  output logic           underrun,
  input  logic           clr_underrun
);

  localparam int PPW = 32 / BPP;
  localparam axis_timing_t H_T = '{active: 10'(H_ACTIVE), fp: 10'(H_FP),
                                   sync: 10'(H_SYNC), bp: 10'(H_BP)};
  localparam axis_timing_t V_T = '{active: 10'(V_ACTIVE), fp: 10'(V_FP),
                                   sync: 10'(V_SYNC), bp: 10'(V_BP)};
  localparam logic [9:0]  H_LAST      = axis_total(H_T) - 10'd1;
  localparam logic [9:0]  V_LAST      = axis_total(V_T) - 10'd1;
  localparam logic [9:0]  GRP_MASK    = 10'(PPW - 1);
  localparam logic [31:0] FRAME_WORDS = 32'(H_ACTIVE * V_ACTIVE / PPW);

  logic [9:0]     h_q, h_d, v_q, v_d;
  logic           h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic           data_en_q, data_en_d;
  logic [BPP-1:0] pix_q, pix_d;
  logic [31:0]    sr_q, sr_d;
  logic           frame_start_q, frame_start_d;
  logic           underrun_q, underrun_d;
  logic           primed_q, primed_d;
  fetch_state_e   st_q, st_d;
  logic           req_q, req_d;
  logic [31:0]    addr_q, addr_d, remain_q, remain_d;

  logic        active, grp_start, starve;
  logic [31:0] grp_word;
  logic        fifo_push, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  vga_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start_q),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (grp_start),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Raster counters and the registered, mutually aligned video outputs.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (enable) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    frame_start_d = enable && (h_d == '0) && (v_d == V_T.active);

    active    = enable && (h_q < H_T.active) && (v_q < V_T.active);
    grp_start = active && ((h_q & GRP_MASK) == '0);
    // Before the first reload nothing was fetched, so an empty FIFO is expected.
    starve    = grp_start && fifo_empty && primed_q;

    h_sync_d  = (enable && in_sync(h_q, H_T)) ? SYNC_POL : ~SYNC_POL;
    v_sync_d  = (enable && in_sync(v_q, V_T)) ? SYNC_POL : ~SYNC_POL;
    data_en_d = active;

    grp_word = '0;
    pix_d    = '0;
    sr_d     = sr_q;
    if (grp_start) begin
      grp_word = fifo_empty ? '0 : fifo_rdata;
      pix_d    = grp_word[31 -: BPP];
      sr_d     = grp_word << BPP;
    end else if (active) begin
      pix_d = sr_q[31 -: BPP];
      sr_d  = sr_q << BPP;
    end

    underrun_d = underrun_q;
    if (clr_underrun) underrun_d = 1'b0;
    if (starve)       underrun_d = 1'b1;
    primed_d = primed_q || frame_start_q;
  end

  // Fetch engine: one outstanding read, restarted from fb_base at each reload.
  always_comb begin
    st_d      = st_q;
    req_d     = req_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    fifo_push = 1'b0;
    if (frame_start_q) begin
      st_d     = F_IDLE;
      req_d    = 1'b0;
      addr_d   = fb_base;
      remain_d = FRAME_WORDS;
    end else begin
      unique case (st_q)
        F_IDLE: begin
          if (enable && !fifo_full && (remain_q != '0)) begin
            st_d  = F_REQ;
            req_d = 1'b1;
          end
        end
        F_REQ: begin
          if (mem_ack) begin
            fifo_push = 1'b1;
            req_d     = 1'b0;
            addr_d    = addr_q + 32'd1;
            remain_d  = remain_q - 32'd1;
            st_d      = (enable && (remain_q == 32'd1)) ? F_DONE : F_IDLE;
          end
        end
        F_DONE: begin
          if (!enable) st_d = F_IDLE;
        end
        default: begin
          st_d  = F_IDLE;
          req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      h_sync_q      <= ~SYNC_POL;
      v_sync_q      <= ~SYNC_POL;
      data_en_q     <= 1'b0;
      pix_q         <= '0;
      sr_q          <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      primed_q      <= 1'b0;
      st_q          <= F_IDLE;
      req_q         <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      data_en_q     <= data_en_d;
      pix_q         <= pix_d;
      sr_q          <= sr_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      primed_q      <= primed_d;
      st_q          <= st_d;
      req_q         <= req_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign data_en     = data_en_q;
  assign pixel_out   = pix_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a 14x7 raster with 4-bit pixels.
module tb_vga_scanout;

  localparam int FRAME = 14 * 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] fb_base;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        h_sync, v_sync, data_en, frame_start, underrun, clr_underrun;
  logic [3:0]  pixel_out;
  logic [9:0]  h_count, v_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_q[$];
  bit          chk_on = 0;
  int          ack_delay = 0;
  bit          ack_stuck = 0;

  int m_h, m_v;
  bit m_hs, m_vs, m_de;

  vga_scanout #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .BPP (4), .FIFO_DEPTH (16), .SYNC_POL (1'b0)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable), .fb_base (fb_base),
    .mem_req (mem_req), .mem_addr (mem_addr), .mem_ack (mem_ack),
    .mem_rdata (mem_rdata), .h_sync (h_sync), .v_sync (v_sync),
    .data_en (data_en), .pixel_out (pixel_out), .frame_start (frame_start),
    .h_count (h_count), .v_count (v_count), .underrun (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h12345678 + a * 32'h11111111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster: counts and what the registered outputs must show.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h <= 0; m_v <= 0; m_hs <= 1'b1; m_vs <= 1'b1; m_de <= 1'b0;
    end else begin
      m_de <= enable && (m_h < 8) && (m_v < 4);
      m_hs <= !(enable && (m_h >= 10) && (m_h < 12));
      m_vs <= !(enable && (m_v == 5));
      if (!enable) begin
        m_h <= 0; m_v <= 0;
      end else if (m_h == 13) begin
        m_h <= 0;
        m_v <= (m_v == 6) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && chk_on) begin
      check("h_count", 32'(h_count), m_h);
      check("v_count", 32'(v_count), m_v);
      check("h_sync", 32'(h_sync), 32'(m_hs));
      check("v_sync", 32'(v_sync), 32'(m_vs));
      check("data_en", 32'(data_en), 32'(m_de));
      check("frame_start", 32'(frame_start), 32'(m_h == 0 && m_v == 4));
      e = 4'h0;
      if (m_de && exp_q.size() > 0) e = exp_q.pop_front();
      check("pixel_out", 32'(pixel_out), 32'(e));
    end
  end

  // Memory responder: acks after ack_delay cycles, feeds the pixel scoreboard.
  initial begin
    logic [31:0] held, w;
    int wait_cnt;
    bit req_seen;
    wait_cnt = 0; req_seen = 0; held = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        wait_cnt = 0; req_seen = 0;
      end else begin
        if (!req_seen) begin
          held = mem_addr; req_seen = 1;
        end else begin
          check("addr_stable", mem_addr, held);
        end
        if (!ack_stuck) begin
          if (wait_cnt >= ack_delay) begin
            w = mem_word(mem_addr);
            mem_ack = 1'b1;
            mem_rdata = w;
            for (int k = 0; k < 8; k++) exp_q.push_back(w[31-4*k -: 4]);
            wait_cnt = 0; req_seen = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic wait_counts(input int h, input int v, input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (h_count == 10'(h) && v_count == 10'(v)) hit = 1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_frame_start(input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (frame_start) hit = 1;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1; enable = 1'b0; fb_base = '0; mem_ack = 1'b0; mem_rdata = '0;
    clr_underrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_h_sync", 32'(h_sync), 32'd1);
    check("rst_v_sync", 32'(v_sync), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_data_en", 32'(data_en), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    chk_on = 1;
    @(posedge clk); #1;
    enable = 1'b1;

    // Plain scanout with a fast memory.
    repeat (3 * FRAME) @(posedge clk);
    check("underrun_fast", 32'(underrun), 32'd0);

    // Slow memory.
    ack_delay = 3;
    repeat (2 * FRAME) @(posedge clk);
    check("underrun_slow", 32'(underrun), 32'd0);

    // Rebase mid-frame.
    wait_counts(3, 1, 2 * FRAME, "wait_line1");
    fb_base = 32'd100;
    wait_frame_start(2 * FRAME, "wait_fs_rebase");
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (mem_req) hit = 1;
    end
    check("rebase_req_seen", 32'(hit), 32'd1);
    check("rebase_addr", mem_addr, 32'd100);
    repeat (FRAME) @(posedge clk);

    // Pause during vertical blanking, then resume from the origin.
    wait_counts(0, 6, 2 * FRAME, "wait_vblank");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("disabled_req", 32'(mem_req), 32'd0);
    enable = 1'b1;
    repeat (2 * FRAME) @(posedge clk);
    check("underrun_resume", 32'(underrun), 32'd0);

    // Starvation.
    ack_stuck = 1;
    do_reset();
    wait_frame_start(2 * FRAME, "wait_fs_starve");
    wait_counts(2, 0, FRAME, "wait_starve_line0");
    check("starve_underrun", 32'(underrun), 32'd1);
    check("starve_req_held", 32'(mem_req), 32'd1);
    wait_counts(3, 0, 20, "wait_clr_point");
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);
    wait_counts(1, 1, 30, "wait_starve_line1");
    check("underrun_reset", 32'(underrun), 32'd1);

    // Reset while a request is outstanding.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_h_count", 32'(h_count), 32'd0);
    check("mid_rst_v_count", 32'(v_count), 32'd0);
    check("mid_rst_h_sync", 32'(h_sync), 32'd1);
    check("mid_rst_v_sync", 32'(v_sync), 32'd1);
    check("mid_rst_data_en", 32'(data_en), 32'd0);
    check("mid_rst_pixel", 32'(pixel_out), 32'd0);
    check("mid_rst_frame_start", 32'(frame_start), 32'd0);
    ack_stuck = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    wait_frame_start(2 * FRAME, "wait_fs_after_rst");
    check("fs_h_count", 32'(h_count), 32'd0);
    check("fs_v_count", 32'(v_count), 32'd4);
    repeat (2 * FRAME) @(posedge clk);
    check("underrun_final", 32'(underrun), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size() <= 32), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 SHALL have parameter BPP, 1, bits per pixel; legal values 1, 2, 4, 8; PPW = 32/BPP pixels per word.
REQ-005 SHALL have parameter FIFO_DEPTH, 16, prefetch words; power of two, at least 2.
REQ-006 SHALL have parameter SYNC_POL, 0, active level of h_sync and v_sync.
REQ-007 Port list (one clock; reset is asynchronous and active-high):
 clk  in  1  pixel clock
 rst  in  1  asynchronous active-high reset
 enable  in  1  run timing and fetch
 fb_base  in  32  framebuffer word address, sampled at frame reload
 mem_req  out  1  word read request
 mem_addr  out  32  word address
 mem_ack  in  1  read accepted; mem_rdata valid this cycle
 mem_rdata  in  32  read data
 h_sync  out  1  horizontal sync
 v_sync  out  1  vertical sync
 data_en  out  1  visible-region strobe
 pixel_out  out  BPP  pixel value
 frame_start  out  1  one-cycle pulse at frame reload
 h_count  out  10  horizontal position
 v_count  out  10  vertical position
 underrun  out  1  sticky starvation flag
 clr_underrun  in  1  clears underrun

Function
REQ-008 h_count SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters) and wrap to 0; v_count SHALL increment on each h wrap, 0..V_TOTAL-1, and wrap to 0.
REQ-009 Region order per axis SHALL be active, front porch, sync, back porch; e.g. h_sync is asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC.
REQ-010 h_sync, v_sync, data_en and pixel_out SHALL be registered and mutually aligned, lagging h_count/v_count by exactly 1 cycle.
REQ-011 data_en SHALL be 1 only when both counts are in the active region; pixel_out SHALL be 0 whenever data_en is 0.
REQ-012 At h_count==0 and v_count==V_ACTIVE, frame reload SHALL occur: FIFO flushed, fetch address loaded from fb_base, remaining-word count set to H_ACTIVE*V_ACTIVE/PPW, frame_start pulsed for 1 cycle.
REQ-013 Fetch FSM SHALL have states F_IDLE, F_REQ, F_DONE: F_IDLE->F_REQ when the FIFO has a free slot and words remain; F_REQ holds mem_req=1 with stable mem_addr until mem_ack; on ack, push mem_rdata, increment the address by 1, and decrement the count; count 0 -> F_DONE; F_DONE->F_IDLE at reload.
REQ-014 At most one request SHALL be outstanding; mem_req SHALL NOT be raised while the FIFO is full.
REQ-015 A word SHALL be popped at the first active pixel of each PPW group; pixels SHALL be emitted MSB-first, BPP bits each.
REQ-016 If the FIFO is empty at a pop, the group SHALL output 0, set underrun, and consume no word.
REQ-017 Simultaneous pop and push SHALL both take effect; a full FIFO with a simultaneous pop SHALL accept the push.
REQ-018 clr_underrun SHALL clear underrun; a new underrun event in the same cycle SHALL win.
REQ-019 enable=0 SHALL hold the counts at 0, hold syncs inactive, keep data_en=0, and send the fetch FSM to F_IDLE after any pending ack; a rise of enable SHALL start at h_count=0, v_count=0.
REQ-020 A change to fb_base mid-frame SHALL take effect only at the next reload.

Reset
REQ-021 rst SHALL asynchronously set counts to 0, syncs to ~SYNC_POL, mem_req/data_en/pixel_out/frame_start/underrun to 0, FIFO to empty, FSM to F_IDLE, and address to 0.
REQ-022 rst during F_REQ SHALL drop mem_req immediately; the first frame after reset SHALL output 0 pixels until the first reload.

Structure
REQ-023 Package vga_pkg SHALL hold the fetch-state enum, the default 640x480 timing constants, and a timing-parameter struct.
REQ-024 The FIFO SHALL be sub-module vga_word_fifo (parameterised width and depth, flush input, full/empty outputs).

Verification
REQ-025 Timing: H 8/2/2/2, V 4/1/1/1, BPP 1 -> h_sync low for clocks 10-11 of every 14-clock line; v_sync low on line 5 of every 7.
REQ-026 Pixels: BPP 4, memory word 0 = 32'h12345678 -> first active line starts 1,2,3,4,5,6,7,8.
REQ-027 Backpressure: mem_ack delayed 3 cycles per request -> mem_addr stable while mem_req=1; no underrun at FIFO_DEPTH 16.
REQ-028 Starvation: mem_ack never asserted -> pixel_out=0, underrun=1; clr_underrun pulse with mem_ack still stuck -> underrun re-sets at the next group.
REQ-029 Reset mid-request: rst during F_REQ -> all outputs at reset values in the same cycle; after release, frame_start pulses at v_count 4, h_count 0.
REQ-030 Rebase: fb_base changed mid-frame -> the first request after the next frame_start uses the new value.
